// File: rtl/output_buffer_streamer.sv
// Streams a flat buffer of signed samples out one per valid/ready handshake, in index order.
// Optional shadow buffer for gapless back-to-back streaming: define STREAMER_DOUBLE_BUFFER_EN.
module output_buffer_streamer #(
  parameter int buff_size   = 32,
  parameter int sample_size = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             load_valid,
  input  logic [buff_size*sample_size-1:0] load_buffer,
  output logic                             load_ready,
  output logic [sample_size-1:0]           sample_out,
  output logic                             sample_valid,
  input  logic                             sample_ready,
  output logic                             sample_last,
  output logic                             busy,
  output logic                             state_dbg
);

  // Handshakes: a load completes on load_valid && load_ready, a sample on
  // sample_valid && sample_ready. Valid never waits on ready, and no output
  // depends combinationally on load_valid or sample_ready.

  localparam int IW = $clog2(buff_size);
  localparam logic [IW-1:0] LAST_IDX = IW'(buff_size - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                           state;
  logic [IW-1:0]                    index;
  logic [buff_size*sample_size-1:0] active;
  logic                             xfer;
  logic                             at_last;

`ifdef STREAMER_DOUBLE_BUFFER_EN
  logic [buff_size*sample_size-1:0] shadow;
  logic                             shadow_full;
`endif

  assign state_dbg    = state;
  assign sample_valid = (state == STREAM);
  assign busy         = (state == STREAM);
  assign at_last      = (index == LAST_IDX);
  assign sample_last  = (state == STREAM) && at_last;
  assign sample_out   = (state == STREAM) ? active[int'(index) * sample_size +: sample_size]
                                          : '0;
  assign xfer         = sample_valid && sample_ready;

`ifdef STREAMER_DOUBLE_BUFFER_EN
  assign load_ready = (state == IDLE) || !shadow_full;
`else
  assign load_ready = (state == IDLE);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      index  <= '0;
      active <= '0;
`ifdef STREAMER_DOUBLE_BUFFER_EN
      shadow      <= '0;
      shadow_full <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            active <= load_buffer;
            index  <= '0;
            state  <= STREAM;
          end
        end
        STREAM: begin
`ifdef STREAMER_DOUBLE_BUFFER_EN
          if (xfer && at_last) begin
            // Final sample leaves: refill from shadow, or straight from the
            // port when a load lands in this same cycle, else go idle.
            if (shadow_full) begin
              active      <= shadow;
              index       <= '0;
              shadow_full <= 1'b0;
            end else if (load_valid) begin
              active <= load_buffer;
              index  <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (xfer) begin
              index <= index + 1'b1;
            end
            if (load_valid && !shadow_full) begin
              shadow      <= load_buffer;
              shadow_full <= 1'b1;
            end
          end
`else
          if (xfer) begin
            if (at_last) begin
              state <= IDLE;
            end else begin
              index <= index + 1'b1;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_buffer_streamer.sv
// Self-checking bench for output_buffer_streamer (buff_size=4, sample_size=16):
// directed scenarios plus random traffic against a queue-based sample model.
module tb_output_buffer_streamer;

  localparam int BS = 4;
  localparam int SW = 16;
`ifdef STREAMER_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic            clock;
  logic            reset;
  logic            load_valid;
  logic [BS*SW-1:0] load_buffer;
  logic            load_ready;
  logic [SW-1:0]   sample_out;
  logic            sample_valid;
  logic            sample_ready;
  logic            sample_last;
  logic            busy;
  logic            state_dbg;

  int checks = 0;
  int errors = 0;

  // Model: exp_q holds the samples still to be emitted from the active buffer
  // (front = presented now); sh_q holds a queued next buffer.
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] sh_q[$];
  bit            last_ld;

  output_buffer_streamer #(.buff_size(BS), .sample_size(SW)) dut (
    .clock       (clock),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_buffer (load_buffer),
    .load_ready  (load_ready),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_last (sample_last),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    if (exp_q.size() == 0) return 1'b1;
    return DB && (sh_q.size() == 0);
  endfunction

  // Compare outputs with the model, then advance one clock and update the model.
  task automatic step();
    bit             v;
    bit             xfer;
    bit             ld;
    logic [BS*SW-1:0] buf_v;
    logic [SW-1:0]  nb[$];
    v = exp_q.size() > 0;
    check("valid", sample_valid, v);
    check("busy", busy, v);
    check("load_ready", load_ready, m_ready());
    if (v) begin
      check("out", sample_out, exp_q[0]);
      check("last", sample_last, exp_q.size() == 1);
    end else begin
      check("last_idle", sample_last, 0);
    end
    xfer  = v && sample_ready;
    ld    = load_valid && m_ready();
    buf_v = load_buffer;
    @(posedge clock);
    if (xfer) void'(exp_q.pop_front());
    if (ld) begin
      for (int i = 0; i < BS; i++) nb.push_back(buf_v[i*SW +: SW]);
      if (exp_q.size() == 0) exp_q = nb;
      else sh_q = nb;
    end
    if (exp_q.size() == 0 && sh_q.size() > 0) begin
      exp_q = sh_q;
      sh_q.delete();
    end
    last_ld = ld;
    #1;
  endtask

  // Asynchronous reset pulse placed away from clock edges.
  task automatic do_reset();
    #2;
    reset      = 1'b0;
    load_valid = 1'b0;
    exp_q.delete();
    sh_q.delete();
    #1;
    check("rst_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", load_ready, 1);
    check("rst_last", sample_last, 0);
    check("rst_out", sample_out, 0);
    @(posedge clock);
    #1;
    check("rst_hold_valid", sample_valid, 0);
    check("rst_hold_out", sample_out, 0);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic load_one(input logic [BS*SW-1:0] b);
    load_buffer = b;
    load_valid  = 1'b1;
    step();
    load_valid  = 1'b0;
  endtask

  initial begin
    logic [BS*SW-1:0] sgn;
    logic [SW-1:0]    w;
    reset        = 1'b0;
    load_valid   = 1'b0;
    load_buffer  = '0;
    sample_ready = 1'b0;
    #1;
    do_reset();

    // Idle with nothing driven
    repeat (3) step();
    check("idle_ready", load_ready, 1);

    // Basic stream
    sample_ready = 1'b1;
    load_one({16'h0004, 16'h0003, 16'h0002, 16'h0001});
    for (int i = 1; i <= BS; i++) begin
      check("basic_out", sample_out, i);
      check("basic_last", sample_last, i == BS);
      step();
    end
    check("basic_end_valid", sample_valid, 0);
    check("basic_end_ready", load_ready, 1);
    step();

    // Backpressure on 0x0002
    load_one({16'h0004, 16'h0003, 16'h0002, 16'h0001});
    step();
    sample_ready = 1'b0;
    repeat (3) begin
      check("bp_out", sample_out, 16'h0002);
      check("bp_valid", sample_valid, 1);
      check("bp_last", sample_last, 0);
      step();
    end
    sample_ready = 1'b1;
    step();
    check("bp_resume", sample_out, 16'h0003);
    repeat (3) step();

    // Signed passthrough
    sgn = {16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
    load_one(sgn);
    for (int i = 0; i < BS; i++) begin
      w = sgn[i*SW +: SW];
      check("signed_out", sample_out, w);
      step();
    end
    step();

    // Back-to-back: A at N, B offered from N+2
    load_one({16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0});
    step();
    load_buffer = {16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0};
    load_valid  = 1'b1;
    check("b2b_ready_n2", load_ready, DB);
    last_ld = 1'b0;
    for (int i = 0; i < 8 && !last_ld; i++) step();
    check("b2b_accepted", last_ld, 1);
    load_valid = 1'b0;
    repeat (BS + 4) step();

    // Mid-stream reset while 0x0002 is presented
    load_one({16'h0004, 16'h0003, 16'h0002, 16'h0001});
    step();
    check("mid_pre", sample_out, 16'h0002);
    do_reset();
    load_one({16'h0014, 16'h0013, 16'h0012, 16'h0011});
    check("mid_restart", sample_out, 16'h0011);
    repeat (BS + 1) step();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      load_valid   = ($urandom_range(0, 1) == 1);
      sample_ready = ($urandom_range(0, 9) < 7);
      load_buffer  = {$urandom(), $urandom()};
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
